outer_product_mac: RTL and testbench

OUTER_PRODUCT_MAC -- requirements
Module: outer_product_mac

---
 rtl/outer_product_mac_pkg.sv | 16 +
 rtl/outer_product_mac_cell.sv | 41 ++++
 rtl/outer_product_mac.sv | 179 +++++++++++++++++
 tb/tb_outer_product_mac.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/outer_product_mac_pkg.sv
// Shared widths, dimensions and FSM encoding for the 3x3 outer-product MAC.
package outer_product_mac_pkg;

  localparam int unsigned ELEM_W = 4;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned DIM    = 3;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/outer_product_mac_cell.sv
// Single unsigned multiply-accumulate cell with synchronous clear and enable.
module mac_cell #(
  parameter int unsigned ELEM_W = outer_product_mac_pkg::ELEM_W,
  parameter int unsigned ACC_W  = outer_product_mac_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [ELEM_W-1:0] a_i,
  input  logic [ELEM_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);
  import outer_product_mac_pkg::*;

  logic [2*ELEM_W-1:0] prod;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;

  assign prod = {{ELEM_W{1'b0}}, a_i} * {{ELEM_W{1'b0}}, b_i};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/outer_product_mac.sv
// 3x3 outer-product accumulator: k rank-1 updates, then a row-major drain
// with a valid/ready handshake on the result stream.
module outer_product_mac #(
  parameter int unsigned ELEM_W = outer_product_mac_pkg::ELEM_W,
  parameter int unsigned ACC_W  = outer_product_mac_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ELEM_W-1:0] data_inw1,
  input  logic [ELEM_W-1:0] data_inw2,
  input  logic [ELEM_W-1:0] data_inw3,
  input  logic [ELEM_W-1:0] data_inx1,
  input  logic [ELEM_W-1:0] data_inx2,
  input  logic [ELEM_W-1:0] data_inx3,
  input  logic              ld_mac,
  input  logic              clear_mac,
  input  logic [1:0]        k_len,
  input  logic [1:0]        n_rows,
  input  logic [1:0]        n_cols,
  input  logic              result_ready,
  output logic [ACC_W-1:0]  data_out,
  output logic              out_valid,
  output logic [1:0]        out_row,
  output logic [1:0]        out_col,
  output logic              busy,
  output logic              done
);
  import outer_product_mac_pkg::*;

  logic [ELEM_W-1:0] w_vec [DIM];
  logic [ELEM_W-1:0] x_vec [DIM];
  logic [ACC_W-1:0]  acc   [DIM][DIM];

  state_e           state_q;
  logic [1:0]       k_q, nr_q, nc_q, cnt_q;
  logic [IDX_W-1:0] row_q, col_q;
  logic [ACC_W-1:0] data_out_q;
  logic             out_valid_q, busy_q, done_q;

  logic             acc_en;
  logic [IDX_W-1:0] nxt_row, nxt_col;
  logic             last_elem;
  logic [ACC_W-1:0] sel_val;

  assign w_vec[0] = data_inw1;
  assign w_vec[1] = data_inw2;
  assign w_vec[2] = data_inw3;
  assign x_vec[0] = data_inx1;
  assign x_vec[1] = data_inx2;
  assign x_vec[2] = data_inx3;

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      mac_cell #(
        .ELEM_W (ELEM_W),
        .ACC_W  (ACC_W)
      ) u_cell (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clear_mac),
        .en_i   (acc_en),
        .a_i    (w_vec[i]),
        .b_i    (x_vec[j]),
        .acc_o  (acc[i][j])
      );
    end
  end

  always_comb begin
    acc_en = 1'b0;
    if (!clear_mac) begin
      case (state_q)
        ST_IDLE:  acc_en = ld_mac && (k_len != '0);
        ST_ACCUM: acc_en = 1'b1;
        default:  acc_en = 1'b0;
      endcase
    end
  end

  // Row-major successor of the current index and the accumulator it selects.
  always_comb begin
    nxt_row   = row_q;
    nxt_col   = col_q + 2'd1;
    if (col_q == nc_q - 2'd1) begin
      nxt_col = '0;
      nxt_row = row_q + 2'd1;
    end
    last_elem = (row_q == nr_q - 2'd1) && (col_q == nc_q - 2'd1);
    sel_val   = '0;
    for (int unsigned i = 0; i < DIM; i++) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        if ((IDX_W'(i) == nxt_row) && (IDX_W'(j) == nxt_col)) begin
          sel_val = acc[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      nr_q        <= '0;
      nc_q        <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear_mac) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ld_mac) begin
            k_q    <= k_len;
            nr_q   <= n_rows;
            nc_q   <= n_cols;
            cnt_q  <= (k_len != '0) ? 2'd1 : 2'd0;
            row_q  <= '0;
            col_q  <= '0;
            busy_q <= 1'b1;
            state_q <= (k_len <= 2'd1) ? ST_DRAIN : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q + 2'd1 == k_q) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // First DRAIN cycle loads element (0,0); afterwards advance on handshake.
          if (!out_valid_q) begin
            if ((nr_q == '0) || (nc_q == '0)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              out_valid_q <= 1'b1;
              data_out_q  <= acc[0][0];
            end
          end else if (result_ready) begin
            if (last_elem) begin
              out_valid_q <= 1'b0;
              state_q     <= ST_DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              row_q      <= nxt_row;
              col_q      <= nxt_col;
              data_out_q <= sel_val;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_outer_product_mac.sv
// Self-checking bench for outer_product_mac: vector table plus scoreboard queue.
module tb_outer_product_mac;

  logic       clk;
  logic       rst;
  logic [3:0] data_inw1, data_inw2, data_inw3;
  logic [3:0] data_inx1, data_inx2, data_inx3;
  logic       ld_mac, clear_mac, result_ready;
  logic [1:0] k_len, n_rows, n_cols;
  logic [9:0] data_out;
  logic       out_valid, busy, done;
  logic [1:0] out_row, out_col;

  outer_product_mac #(
    .ELEM_W (4),
    .ACC_W  (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_inw1    (data_inw1),
    .data_inw2    (data_inw2),
    .data_inw3    (data_inw3),
    .data_inx1    (data_inx1),
    .data_inx2    (data_inx2),
    .data_inx3    (data_inx3),
    .ld_mac       (ld_mac),
    .clear_mac    (clear_mac),
    .k_len        (k_len),
    .n_rows       (n_rows),
    .n_cols       (n_cols),
    .result_ready (result_ready),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .out_row      (out_row),
    .out_col      (out_col),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
    logic [9:0] v;
  } exp_t;

  // w[t*3+i] = W column t row i; x[t*3+j] = X row t column j; exp[i*3+j].
  typedef struct packed {
    logic [8:0][3:0] w;
    logic [8:0][3:0] x;
    logic [1:0]      k;
    logic [1:0]      nr;
    logic [1:0]      nc;
    logic            stall;
    logic            drop_ld;
    logic            use_model;
    logic [8:0][9:0] exp;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[8];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int first_hs = 0;
  int last_hs = 0;
  bit hold_en = 1'b1;
  bit held = 1'b0;
  logic [9:0] held_v;
  logic [1:0] held_r, held_c;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: scoreboard pops on handshake, stall stability, done count.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      held = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (held && hold_en) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(data_out), int'(held_v));
        chk("hold_row", int'(out_row), int'(held_r));
        chk("hold_col", int'(out_col), int'(held_c));
      end
      if (out_valid && result_ready) begin
        if (sbq.size() == 0) begin
          chk("extra_output", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("data_out", int'(data_out), int'(e.v));
          chk("out_row", int'(out_row), int'(e.r));
          chk("out_col", int'(out_col), int'(e.c));
        end
        if (hs_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
      end
      held   = out_valid && !result_ready;
      held_v = data_out;
      held_r = out_row;
      held_c = out_col;
    end
  end

  task automatic drive_step(input vec_t v, input int t);
    data_inw1 = v.w[t*3+0];
    data_inw2 = v.w[t*3+1];
    data_inw3 = v.w[t*3+2];
    data_inx1 = v.x[t*3+0];
    data_inx2 = v.x[t*3+1];
    data_inx3 = v.x[t*3+2];
    k_len  = v.k;
    n_rows = v.nr;
    n_cols = v.nc;
  endtask

  task automatic drive_garbage();
    data_inw1 = 4'd15; data_inw2 = 4'd15; data_inw3 = 4'd15;
    data_inx1 = 4'd15; data_inx2 = 4'd15; data_inx3 = 4'd15;
    k_len = 2'd3; n_rows = 2'd3; n_cols = 2'd3;
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int  nsteps;
    bit  got;
    nsteps   = (v.k == 2'd0) ? 1 : int'(v.k);
    done_cnt = 0;
    hs_cnt   = 0;
    for (int i = 0; i < int'(v.nr); i++)
      for (int j = 0; j < int'(v.nc); j++)
        sbq.push_back('{r: 2'(i), c: 2'(j), v: v.exp[i*3+j]});
    result_ready = 1'b1;
    for (int t = 0; t < nsteps; t++) begin
      drive_step(v, t);
      ld_mac = !(v.drop_ld && t == 1);
      @(posedge clk); #1;
    end
    // Memory bank keeps ld_mac high with unrelated data; must not add.
    drive_garbage();
    ld_mac = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      result_ready = v.stall ? (n % 3 == 0) : 1'b1;
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    chk({tag, "_valid_in_done"}, int'(out_valid), 0);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_sb_left"}, sbq.size(), 0);
    chk({tag, "_emitted"}, hs_cnt, int'(v.nr) * int'(v.nc));
    if (!v.stall && hs_cnt > 0) chk({tag, "_back_to_back"}, last_hs - first_hs, hs_cnt - 1);
    sbq.delete();
    ld_mac    = 1'b0;
    clear_mac = 1'b1;
    @(posedge clk); #1;
    clear_mac = 1'b0;
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit   ok;
    vec_t v;
    rst = 1'b1; ld_mac = 1'b0; clear_mac = 1'b0; result_ready = 1'b1;
    data_inw1 = '0; data_inw2 = '0; data_inw3 = '0;
    data_inx1 = '0; data_inx2 = '0; data_inx3 = '0;
    k_len = '0; n_rows = '0; n_cols = '0;

    for (int n = 0; n < 8; n++) vecs[n] = '0;
    // 0: identity W, X = 1..9
    vecs[0].k = 3; vecs[0].nr = 3; vecs[0].nc = 3;
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 3; i++) begin
        vecs[0].w[t*3+i] = (t == i) ? 4'd1 : 4'd0;
        vecs[0].x[t*3+i] = 4'(t*3 + i + 1);
      end
    vecs[0].exp = {10'd9, 10'd8, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
    // 1: all 15, full depth -> 675 everywhere
    vecs[1].k = 3; vecs[1].nr = 3; vecs[1].nc = 3;
    for (int e = 0; e < 9; e++) begin
      vecs[1].w[e] = 4'd15; vecs[1].x[e] = 4'd15; vecs[1].exp[e] = 10'd675;
    end
    // 2: 2x2 product [1 2;3 4]*[5 6;7 8]
    vecs[2].k = 2; vecs[2].nr = 2; vecs[2].nc = 2;
    vecs[2].w[0] = 4'd1; vecs[2].w[1] = 4'd3; vecs[2].w[3] = 4'd2; vecs[2].w[4] = 4'd4;
    vecs[2].x[0] = 4'd5; vecs[2].x[1] = 4'd6; vecs[2].x[3] = 4'd7; vecs[2].x[4] = 4'd8;
    vecs[2].exp[0] = 10'd19; vecs[2].exp[1] = 10'd22;
    vecs[2].exp[3] = 10'd43; vecs[2].exp[4] = 10'd50;
    // 3: identity under backpressure
    vecs[3] = vecs[0];
    vecs[3].stall = 1'b1;
    // 4: random, 3x2 result, ld_mac drops mid-ACCUM
    vecs[4].k = 3; vecs[4].nr = 3; vecs[4].nc = 2; vecs[4].drop_ld = 1'b1; vecs[4].use_model = 1'b1;
    // 5: random, single-step, 2x3 result, stalled
    vecs[5].k = 1; vecs[5].nr = 2; vecs[5].nc = 3; vecs[5].stall = 1'b1; vecs[5].use_model = 1'b1;
    // 6: empty result (n_rows = 0)
    vecs[6].k = 2; vecs[6].nr = 0; vecs[6].nc = 3; vecs[6].use_model = 1'b1;
    for (int e = 0; e < 9; e++) begin
      vecs[6].w[e] = 4'd9; vecs[6].x[e] = 4'd9;
    end
    // 7: k_len = 0 with non-zero operands -> all zeros
    vecs[7].k = 0; vecs[7].nr = 3; vecs[7].nc = 3;
    for (int e = 0; e < 9; e++) begin
      vecs[7].w[e] = 4'd7; vecs[7].x[e] = 4'd11;
    end
    for (int n = 4; n < 6; n++)
      for (int e = 0; e < 9; e++) begin
        vecs[n].w[e] = 4'($urandom_range(0, 15));
        vecs[n].x[e] = 4'($urandom_range(0, 15));
      end
    for (int n = 0; n < 8; n++)
      if (vecs[n].use_model)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            int s;
            s = 0;
            for (int t = 0; t < int'(vecs[n].k); t++)
              s += int'(vecs[n].w[t*3+i]) * int'(vecs[n].x[t*3+j]);
            vecs[n].exp[i*3+j] = 10'(s);
          end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_row", int'(out_row), 0);
    chk("rst_out_col", int'(out_col), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 7; n++) run_job(vecs[n], $sformatf("vec%0d", n));

    // Reset in the middle of accumulation, then a fresh identity job.
    v = vecs[1];
    drive_step(v, 0);
    ld_mac = 1'b1;
    @(posedge clk); #1;
    drive_step(v, 1);
    @(posedge clk); #1;
    chk("accum_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ld_mac = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(data_out), 0);
    @(posedge clk); #1;
    run_job(vecs[0], "after_rst");

    // Clear in the middle of DRAIN while ld_mac is high: no done, back to IDLE.
    done_cnt = 0;
    result_ready = 1'b0;
    ld_mac = 1'b1;
    for (int t = 0; t < 3; t++) begin
      drive_step(vecs[1], t);
      @(posedge clk); #1;
    end
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("drain_valid_seen", int'(ok), 1);
    repeat (2) @(posedge clk);
    #1;
    hold_en = 1'b0;
    clear_mac = 1'b1;
    @(posedge clk); #1;
    chk("clear_valid_low", int'(out_valid), 0);
    chk("clear_busy_low", int'(busy), 0);
    clear_mac = 1'b0;
    ld_mac = 1'b0;
    result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    hold_en = 1'b1;
    chk("clear_no_done", done_cnt, 0);
    chk("clear_stays_idle", int'(busy), 0);

    // k_len = 0 right after the clear: accumulators must read back zero.
    run_job(vecs[7], "k_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
